// File: rtl/monopix_data_tx.sv
// Chip-side emulator of the MONOPIX token/freeze/read serial readout.
// Buffers injected hits and shifts one hit word out MSB first per READ edge while frozen.
module monopix_data_tx #(
   parameter int unsigned COL_BITS = 6,
   parameter int unsigned ROW_BITS = 8,
   parameter int unsigned TS_BITS  = 8,
   parameter int unsigned DEPTH    = 16
) (
   input  logic                                       CLK,
   input  logic                                       RST,
   input  logic                                       HIT_WR,
   input  logic [COL_BITS+ROW_BITS+2*TS_BITS-1:0]     HIT_DATA,
   output logic                                       HIT_FULL,
   input  logic                                       FREEZE,
   input  logic                                       READ,
   output logic                                       TOKEN,
   output logic                                       DATA,
   output logic                                       BUSY,
   output logic                                       READ_ERR,
   output logic [7:0]                                 LOST_CNT
);

   localparam int unsigned W  = COL_BITS + ROW_BITS + 2 * TS_BITS;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned BW = $clog2(W);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StFrozen = 2'd1;
   localparam logic [1:0] StShift  = 2'd2;

   localparam logic [AW:0]   FullCnt = (AW + 1)'(DEPTH);
   localparam logic [BW-1:0] LastBit = BW'(W - 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   frz_cnt_q, frz_cnt_d;
   logic [1:0]    state_q, state_d;
   logic [W-1:0]  shift_q, shift_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]    lost_q, lost_d;
   logic          read_q, token_q, token_d, err_q, err_d;
   logic          rd_edge, full, pop, push;

   assign rd_edge = READ & ~read_q;
   assign full    = (count_q == FullCnt);
   // A pop in the same cycle frees the slot, so a write into a full buffer still lands.
   assign push    = HIT_WR & (~full | pop);

   always_comb begin
      state_d   = state_q;
      frz_cnt_d = frz_cnt_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      pop       = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         StIdle: begin
            err_d = rd_edge;
            if (FREEZE) begin
               frz_cnt_d = count_q;
               state_d   = StFrozen;
            end
         end
         StFrozen: begin
            if (rd_edge && frz_cnt_q != '0) begin
               pop       = 1'b1;
               shift_d   = mem_q[rd_ptr_q];
               frz_cnt_d = frz_cnt_q - 1'b1;
               bit_cnt_d = LastBit;
               state_d   = StShift;
            end else begin
               err_d = rd_edge;
               if (!FREEZE) state_d = StIdle;
            end
         end
         StShift: begin
            err_d     = rd_edge;
            shift_d   = {shift_q[W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 1'b1;
            if (bit_cnt_q == '0) state_d = FREEZE ? StFrozen : StIdle;
         end
         default: state_d = StIdle;
      endcase

      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      lost_d = lost_q;
      if (HIT_WR && !push && lost_q != 8'hFF) lost_d = lost_q + 1'b1;

      token_d = (state_q == StIdle) ? (count_q != '0) : (frz_cnt_q != '0);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         frz_cnt_q <= '0;
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         lost_q    <= '0;
         read_q    <= 1'b0;
         token_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q   <= count_d;
         frz_cnt_q <= frz_cnt_d;
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         lost_q    <= lost_d;
         read_q    <= READ;
         token_q   <= token_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= HIT_DATA;
   end

   assign HIT_FULL = full;
   assign TOKEN    = token_q;
   assign BUSY     = (state_q == StShift);
   assign DATA     = (state_q == StShift) & shift_q[W-1];
   assign READ_ERR = err_q;
   assign LOST_CNT = lost_q;

endmodule

// File: tb/tb_monopix_data_tx.sv
// Directed bench for monopix_data_tx: token/freeze/read flow, overflow, errors, reset abort.
module tb_monopix_data_tx;

   localparam int W = 30;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         HIT_WR = 1'b0;
   logic [W-1:0] HIT_DATA = '0;
   logic         HIT_FULL;
   logic         FREEZE = 1'b0;
   logic         READ = 1'b0;
   logic         TOKEN, DATA, BUSY, READ_ERR;
   logic [7:0]   LOST_CNT;

   int n_cmp = 0;
   int n_err = 0;

   monopix_data_tx dut (
      .CLK      (CLK),
      .RST      (RST),
      .HIT_WR   (HIT_WR),
      .HIT_DATA (HIT_DATA),
      .HIT_FULL (HIT_FULL),
      .FREEZE   (FREEZE),
      .READ     (READ),
      .TOKEN    (TOKEN),
      .DATA     (DATA),
      .BUSY     (BUSY),
      .READ_ERR (READ_ERR),
      .LOST_CNT (LOST_CNT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1; HIT_WR = 1'b0; READ = 1'b0; FREEZE = 1'b0;
      step(); step();
      RST = 1'b0;
   endtask

   task automatic write_hit(input logic [W-1:0] d);
      HIT_WR = 1'b1; HIT_DATA = d;
      step();
      HIT_WR = 1'b0;
   endtask

   // One READ edge, optionally with a concurrent write and a second READ edge mid-shift.
   task automatic read_word(input logic wr_too, input logic [W-1:0] wd, input int rd2_at,
                            output logic [W-1:0] w, output int nbusy, output int nerr);
      w = '0; nbusy = 0; nerr = 0;
      READ = 1'b1;
      if (wr_too) begin HIT_WR = 1'b1; HIT_DATA = wd; end
      step();
      READ = 1'b0; HIT_WR = 1'b0;
      for (int i = 0; i < W; i++) begin
         w = {w[W-2:0], DATA};
         nbusy += int'(BUSY);
         nerr  += int'(READ_ERR);
         READ = (i == rd2_at);
         step();
      end
      READ = 1'b0;
      nerr += int'(READ_ERR);
   endtask

   logic [W-1:0] w;
   int nb, ne;
   logic [W-1:0] ha, hb, hc, newv;

   initial begin
      // 1: reset state and single-hit readout
      do_reset();
      chk("rst_token", {31'd0, TOKEN}, 32'd0);
      chk("rst_data", {31'd0, DATA}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_full", {31'd0, HIT_FULL}, 32'd0);
      chk("rst_err", {31'd0, READ_ERR}, 32'd0);
      chk("rst_lost", {24'd0, LOST_CNT}, 32'd0);
      write_hit(30'h0512_3456);
      chk("t1_token_lat", {31'd0, TOKEN}, 32'd0);
      step();
      chk("t1_token", {31'd0, TOKEN}, 32'd1);
      FREEZE = 1'b1;
      step();
      read_word(1'b0, '0, -1, w, nb, ne);
      chk("t1_word", {2'd0, w}, 32'h0512_3456);
      chk("t1_busy_cycles", nb, 32'd30);
      chk("t1_read_err", ne, 32'd0);
      chk("t1_data_after", {31'd0, DATA}, 32'd0);
      chk("t1_busy_after", {31'd0, BUSY}, 32'd0);
      chk("t1_token_after", {31'd0, TOKEN}, 32'd0);

      // 2: snapshot semantics
      do_reset();
      ha = 30'h0ABC_DEF1; hb = 30'h3000_0001; hc = 30'h1555_5555;
      write_hit(ha); write_hit(hb); write_hit(hc);
      step();
      FREEZE = 1'b1;
      step();
      write_hit(30'h0000_00D0); write_hit(30'h0000_00E0);
      chk("t2_token_frozen", {31'd0, TOKEN}, 32'd1);
      read_word(1'b0, '0, -1, w, nb, ne);
      chk("t2_word_a", {2'd0, w}, {2'd0, ha});
      read_word(1'b0, '0, -1, w, nb, ne);
      chk("t2_word_b", {2'd0, w}, {2'd0, hb});
      read_word(1'b0, '0, -1, w, nb, ne);
      chk("t2_word_c", {2'd0, w}, {2'd0, hc});
      chk("t2_token_drained", {31'd0, TOKEN}, 32'd0);
      FREEZE = 1'b0;
      step(); step();
      chk("t2_token_unfrozen", {31'd0, TOKEN}, 32'd1);

      // 3 + 5: overflow, simultaneous write/pop when full, saturation
      do_reset();
      for (int i = 0; i < 15; i++) write_hit(W'(i));
      chk("t3_not_full_15", {31'd0, HIT_FULL}, 32'd0);
      write_hit(W'(15));
      chk("t3_full_16", {31'd0, HIT_FULL}, 32'd1);
      chk("t3_lost_0", {24'd0, LOST_CNT}, 32'd0);
      write_hit(W'(16)); write_hit(W'(17));
      chk("t3_lost_2", {24'd0, LOST_CNT}, 32'd2);
      FREEZE = 1'b1;
      step();
      newv = 30'h2AAA_AAAA;
      read_word(1'b1, newv, -1, w, nb, ne);
      chk("t5_word_0", {2'd0, w}, 32'd0);
      chk("t5_still_full", {31'd0, HIT_FULL}, 32'd1);
      chk("t5_no_loss", {24'd0, LOST_CNT}, 32'd2);
      HIT_WR = 1'b1; HIT_DATA = 30'h3FFF_FFFF;
      for (int i = 0; i < 300; i++) step();
      HIT_WR = 1'b0;
      chk("t3_lost_sat", {24'd0, LOST_CNT}, 32'd255);
      for (int i = 1; i < 16; i++) begin
         read_word(1'b0, '0, -1, w, nb, ne);
         chk($sformatf("t5_word_%0d", i), {2'd0, w}, i);
      end
      chk("t5_token_drained", {31'd0, TOKEN}, 32'd0);
      FREEZE = 1'b0;
      step(); step();
      FREEZE = 1'b1;
      step();
      read_word(1'b0, '0, -1, w, nb, ne);
      chk("t5_new_last", {2'd0, w}, {2'd0, newv});

      // 4: illegal READ edges
      do_reset();
      write_hit(30'h0123_4567);
      step();
      READ = 1'b1; step(); READ = 1'b0;
      chk("t4_err_idle", {31'd0, READ_ERR}, 32'd1);
      step();
      chk("t4_err_pulse_len", {31'd0, READ_ERR}, 32'd0);
      chk("t4_idle_no_shift", {31'd0, BUSY}, 32'd0);
      FREEZE = 1'b1;
      step();
      read_word(1'b0, '0, 5, w, nb, ne);
      chk("t4_word_intact", {2'd0, w}, 32'h0123_4567);
      chk("t4_err_shift", ne, 32'd1);
      READ = 1'b1; step(); READ = 1'b0;
      chk("t4_err_frozen0", {31'd0, READ_ERR}, 32'd1);
      chk("t4_frozen0_busy", {31'd0, BUSY}, 32'd0);
      step();
      chk("t4_frozen0_data", {31'd0, DATA}, 32'd0);
      FREEZE = 1'b0;
      step(); step(); step();
      chk("t4_count_empty", {31'd0, TOKEN}, 32'd0);

      // 6: reset in the middle of a shift
      do_reset();
      write_hit(30'h3FFF_FFFF);
      FREEZE = 1'b1;
      step();
      READ = 1'b1; step(); READ = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("t6_busy_pre", {31'd0, BUSY}, 32'd1);
      RST = 1'b1; FREEZE = 1'b0;
      step();
      chk("t6_data", {31'd0, DATA}, 32'd0);
      chk("t6_busy", {31'd0, BUSY}, 32'd0);
      chk("t6_token", {31'd0, TOKEN}, 32'd0);
      RST = 1'b0;
      step(); step(); step();
      chk("t6_count_zero", {31'd0, TOKEN}, 32'd0);
      write_hit(30'h1234_5678);
      step();
      chk("t6_token_fresh", {31'd0, TOKEN}, 32'd1);
      FREEZE = 1'b1;
      step();
      read_word(1'b0, '0, -1, w, nb, ne);
      chk("t6_word_fresh", {2'd0, w}, 32'h1234_5678);
      chk("t6_busy_fresh", nb, 32'd30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
